// File: rtl/comp_result_unpacker.sv
// ---------------------------------------------------------------------------
// comp_result_unpacker
//
// Receiving end of the comp result interface. Every strobed pair of
// 2*p_size-bit results is pushed into a small FIFO. Each pair is then replayed
// as four p_size-bit words on a valid/ready stream, so that narrow consumers
// (registers, UART, bus bridges) can drain it. comp has no ready input, so a
// pair that arrives while the FIFO is full is dropped and flagged in a sticky
// overflow bit instead of stalling comp.
//
// Word order per pair (idx0..idx3):
//   i_param[p_size-1:0], i_param[2*p_size-1:p_size],
//   i_param_2[p_size-1:0], i_param_2[2*p_size-1:p_size]
//
// Parameters:
//   p_size   width of one output word; input results are 2*p_size wide
//   p_depth  FIFO depth in result pairs (power of two, >= 2)
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        asynchronous active-low reset
//   i_dv       result strobe; a pair is captured on every cycle it is high
//   i_param    first result of the pair
//   i_param_2  second result of the pair
//   i_clr      synchronous clear of o_ovf (a coincident overflow wins)
//   o_data     output word
//   o_valid    o_data is valid
//   i_ready    consumer accepts o_data when o_valid && i_ready
//   o_last     high with the fourth word of a pair
//   o_ovf      sticky overflow flag
//   o_level    pairs stored, including the pair currently being emitted
//   o_pair_cnt (only with COMP_RESULT_UNPACKER_CNT_EN) 16-bit wrapping count
//              of completed pairs, not affected by i_clr
//
// Optional feature macro: COMP_RESULT_UNPACKER_CNT_EN
// ---------------------------------------------------------------------------
module comp_result_unpacker #(
   parameter int p_size  = 12,
   parameter int p_depth = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_dv,
   input  logic [2*p_size-1:0]       i_param,
   input  logic [2*p_size-1:0]       i_param_2,
   input  logic                      i_clr,
   output logic [p_size-1:0]         o_data,
   output logic                      o_valid,
   input  logic                      i_ready,
   output logic                      o_last,
   output logic                      o_ovf,
   output logic [$clog2(p_depth):0]  o_level
`ifdef COMP_RESULT_UNPACKER_CNT_EN
   ,
   output logic [15:0]               o_pair_cnt
`endif
);

   localparam int AW = $clog2(p_depth);   // FIFO address width
   localparam int PW = AW + 1;            // pointer width, extra wrap bit
   localparam int EW = 4 * p_size;        // one FIFO entry = one pair

   localparam logic [PW-1:0] DEPTH_L = PW'(p_depth);
   localparam logic [PW-1:0] ONE_L   = PW'(1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // Storage and registered state
   // ------------------------------------------------------------------
   logic [EW-1:0]     mem [p_depth];

   state_t            state_reg;
   logic [PW-1:0]     wr_ptr_reg;
   logic [PW-1:0]     rd_ptr_reg;
   logic [1:0]        idx_reg;
   logic [p_size-1:0] data_reg;
   logic              valid_reg;
   logic              last_reg;
   logic              ovf_reg;

   // ------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------
   logic [PW-1:0]     level;
   logic              xfer;
   logic              pop;
   logic              push;
   logic              drop;
   logic [1:0]        idx_next;
   logic [AW-1:0]     rd_addr;
   logic [AW-1:0]     rd_addr_next;
   logic [EW-1:0]     head_entry;
   logic [p_size-1:0] head_words [4];
   logic [p_size-1:0] next_word0;
   logic [EW-1:0]     in_entry;

   // Pointer difference is exact thanks to the extra wrap bit.
   assign level    = wr_ptr_reg - rd_ptr_reg;

   assign xfer     = valid_reg && i_ready;
   assign pop      = xfer && (idx_reg == 2'd3);

   // A pop in the same cycle frees a slot, so a full FIFO still accepts.
   assign push     = i_dv && ((level != DEPTH_L) || pop);
   assign drop     = i_dv && !push;

   assign idx_next     = idx_reg + 2'd1;
   assign rd_addr      = rd_ptr_reg[AW-1:0];
   assign rd_addr_next = rd_addr + AW'(1);

   assign head_entry = mem[rd_addr];
   assign next_word0 = mem[rd_addr_next][p_size-1:0];
   assign in_entry   = {i_param_2, i_param};

   // Slice the head entry into its four output words.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_head_words
         assign head_words[gi] = head_entry[gi*p_size +: p_size];
      end
   endgenerate

   // ------------------------------------------------------------------
   // FIFO storage. No reset: contents are meaningless while the pointers
   // say empty, and a write during reset is never read because the
   // pointers are held at zero.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg[AW-1:0]] <= in_entry;
      end
   end

   // ------------------------------------------------------------------
   // Pointers, overflow flag and the output FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg  <= IDLE;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         idx_reg    <= 2'd0;
         data_reg   <= '0;
         valid_reg  <= 1'b0;
         last_reg   <= 1'b0;
         ovf_reg    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + ONE_L;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + ONE_L;
         end

         // Set has priority over clear.
         if (drop) begin
            ovf_reg <= 1'b1;
         end else if (i_clr) begin
            ovf_reg <= 1'b0;
         end

         case (state_reg)
            IDLE: begin
               idx_reg  <= 2'd0;
               last_reg <= 1'b0;
               if (level != '0) begin
                  // Defensive: data already queued while idle.
                  state_reg <= SEND;
                  valid_reg <= 1'b1;
                  data_reg  <= head_words[0];
               end else if (push) begin
                  // Bypass the FIFO for the first word so o_valid follows
                  // i_dv by a single cycle.
                  state_reg <= SEND;
                  valid_reg <= 1'b1;
                  data_reg  <= i_param[p_size-1:0];
               end
            end

            SEND: begin
               if (xfer) begin
                  if (idx_reg != 2'd3) begin
                     idx_reg  <= idx_next;
                     data_reg <= head_words[idx_next];
                     last_reg <= (idx_next == 2'd3);
                  end else begin
                     idx_reg  <= 2'd0;
                     last_reg <= 1'b0;
                     if (level > ONE_L) begin
                        // Another pair is already stored behind the head.
                        data_reg <= next_word0;
                     end else if (push) begin
                        // Queue empties but a pair arrives this very cycle;
                        // its entry is not written yet, so take it directly.
                        data_reg <= i_param[p_size-1:0];
                     end else begin
                        state_reg <= IDLE;
                        valid_reg <= 1'b0;
                     end
                  end
               end
            end

            default: begin
               state_reg <= IDLE;
               valid_reg <= 1'b0;
               last_reg  <= 1'b0;
               idx_reg   <= 2'd0;
            end
         endcase
      end
   end

`ifdef COMP_RESULT_UNPACKER_CNT_EN
   // Completed-pair counter; wraps naturally at 16 bits.
   logic [15:0] pair_cnt_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pair_cnt_reg <= 16'd0;
      end else if (pop) begin
         pair_cnt_reg <= pair_cnt_reg + 16'd1;
      end
   end

   assign o_pair_cnt = pair_cnt_reg;
`endif

   assign o_data  = data_reg;
   assign o_valid = valid_reg;
   assign o_last  = last_reg;
   assign o_ovf   = ovf_reg;
   assign o_level = level;

endmodule
